// File: rtl/adiabatic_clock_phaser.sv
// Four-phase trapezoidal power-clock step-code sequencer for the adiabatic driver cells.
// Each phase ramps up, holds, ramps down and waits, running one segment behind the previous phase.
module adiabatic_clock_phaser #(
    parameter  int SEG = 8,
    localparam int CW  = $clog2(SEG + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            stall,
    output logic [4*CW-1:0] clkpos_code,
    output logic [4*CW-1:0] clkneg_code,
    output logic [3:0]      active,
    output logic            running,
    output logic            period_start
);
    localparam int SW = (SEG > 1) ? $clog2(SEG) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [SW-1:0] CNT_LAST  = SW'(SEG - 1);
    localparam logic [CW-1:0] CODE_FULL = CW'(SEG);

    logic [1:0]      state, state_nx;
    logic [SW-1:0]   seg_cnt, cnt_nx;
    logic [1:0]      seg_idx, idx_nx;
    logic [3:0]      act_nx;
    logic [4*CW-1:0] pos_nx, neg_nx;
    logic            upd, arm_ok, ps_nx;

    // Trapezoid step code for one phase given its own segment number s.
    function automatic logic [CW-1:0] phase_code(input logic [1:0]    s,
                                                 input logic [SW-1:0] cnt,
                                                 input logic          armed);
        logic [CW-1:0] c;
        c = '0;
        if (armed) begin
            case (s)
                2'd0:    c = CW'(cnt) + CW'(1);
                2'd1:    c = CODE_FULL;
                2'd2:    c = CODE_FULL - CW'(1) - CW'(cnt);
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = seg_cnt;
        idx_nx   = seg_idx;
        act_nx   = active;
        upd      = 1'b0;
        arm_ok   = 1'b0;
        pos_nx   = '0;
        neg_nx   = '0;
        ps_nx    = 1'b0;

        case (state)
            ST_IDLE: begin
                // Start only on an unstalled edge so phase 0 arms on the very first counter value.
                if (en && !stall) begin
                    state_nx = ST_RUN;
                    upd      = 1'b1;
                    arm_ok   = 1'b1;
                end
            end
            default: begin
                if (en)
                    state_nx = ST_RUN;
                else if (state == ST_DRAIN && active == 4'b0000 && !stall)
                    state_nx = ST_IDLE;
                else
                    state_nx = ST_DRAIN;

                if (!stall) begin
                    upd    = 1'b1;
                    arm_ok = (state_nx == ST_RUN);
                    if (state_nx == ST_IDLE) begin
                        cnt_nx = '0;
                        idx_nx = '0;
                    end else if (seg_cnt == CNT_LAST) begin
                        cnt_nx = '0;
                        idx_nx = seg_idx + 2'd1;
                    end else begin
                        cnt_nx = seg_cnt + SW'(1);
                    end
                end
            end
        endcase

        if (upd) begin
            for (int k = 0; k < 4; k++) begin
                if ((idx_nx - 2'(k)) == 2'd0 && cnt_nx == '0 && arm_ok)
                    act_nx[k] = 1'b1;
                else if ((idx_nx - 2'(k)) == 2'd3)
                    act_nx[k] = 1'b0;
            end
        end

        for (int k = 0; k < 4; k++) begin
            pos_nx[k*CW +: CW] = phase_code(idx_nx - 2'(k), cnt_nx, act_nx[k]);
            neg_nx[k*CW +: CW] = CODE_FULL - pos_nx[k*CW +: CW];
        end

        // period_start is an event, so a stalled or idle edge never repeats it.
        ps_nx = upd && (state_nx != ST_IDLE) && idx_nx == 2'd0 && cnt_nx == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            seg_cnt      <= '0;
            seg_idx      <= '0;
            active       <= '0;
            clkpos_code  <= '0;
            clkneg_code  <= {4{CODE_FULL}};
            running      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nx;
            running      <= (state_nx != ST_IDLE);
            period_start <= ps_nx;
            if (upd) begin
                seg_cnt     <= cnt_nx;
                seg_idx     <= idx_nx;
                active      <= act_nx;
                clkpos_code <= pos_nx;
                clkneg_code <= neg_nx;
            end
        end
    end

endmodule

// File: tb/tb_adiabatic_clock_phaser.sv
// Self-checking bench for adiabatic_clock_phaser: behavioural period/trapezoid model,
// per-cycle compare process, directed start-up/drain/stall/reset scenarios and random traffic.
module tb_adiabatic_clock_phaser;
    localparam int SEG = 8;
    localparam int CW  = $clog2(SEG + 1);
    localparam int PER = 4 * SEG;

    logic            clk;
    logic            rst_n = 1'b0;
    logic            en    = 1'b0;
    logic            stall = 1'b0;
    logic [4*CW-1:0] clkpos_code;
    logic [4*CW-1:0] clkneg_code;
    logic [3:0]      active;
    logic            running;
    logic            period_start;

    int checks = 0;
    int errors = 0;

    adiabatic_clock_phaser #(.SEG(SEG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .stall        (stall),
        .clkpos_code  (clkpos_code),
        .clkneg_code  (clkneg_code),
        .active       (active),
        .running      (running),
        .period_start (period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int field(input logic [4*CW-1:0] v, input int k);
        return int'(v[k*CW +: CW]);
    endfunction

    // Model: m_t is the position within the 4*SEG period; each phase sees the
    // period shifted by k*SEG and draws a trapezoid if it was armed at its window start.
    int m_state;  // 0 idle, 1 run, 2 drain
    int m_t;
    bit m_arm [4];
    bit m_ps;

    function automatic int pos_of(input int k);
        return (m_t - k * SEG + PER) % PER;
    endfunction

    function automatic int trap(input int p);
        if (p < SEG)     return p + 1;
        if (p < 2 * SEG) return SEG;
        if (p < 3 * SEG) return 3 * SEG - 1 - p;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_t     = 0;
        m_ps    = 1'b0;
        for (int k = 0; k < 4; k++) m_arm[k] = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit s);
        int nxt;
        bit none;
        m_ps = 1'b0;
        if (m_state == 0) begin
            if (e && !s) begin
                m_state = 1;
                m_t     = 0;
                for (int k = 0; k < 4; k++) m_arm[k] = (pos_of(k) == 0);
                m_ps = 1'b1;
            end
        end else begin
            none = 1'b1;
            for (int k = 0; k < 4; k++) if (m_arm[k]) none = 1'b0;
            nxt = e ? 1 : ((m_state == 2 && none && !s) ? 0 : 2);
            if (!s) begin
                m_t = (nxt == 0) ? 0 : (m_t + 1) % PER;
                for (int k = 0; k < 4; k++) begin
                    if (pos_of(k) == 0 && nxt == 1) m_arm[k] = 1'b1;
                    else if (pos_of(k) >= 3 * SEG)  m_arm[k] = 1'b0;
                end
                m_ps = (nxt != 0) && (m_t == 0);
            end
            m_state = nxt;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(en, stall);
        end
    end

    // Compare process: every negedge the DUT must match the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("pos%0d", k), field(clkpos_code, k), m_arm[k] ? trap(pos_of(k)) : 0);
                check($sformatf("neg%0d", k), field(clkneg_code, k), SEG - (m_arm[k] ? trap(pos_of(k)) : 0));
                check($sformatf("active%0d", k), int'(active[k]), int'(m_arm[k]));
            end
            check("running", int'(running), (m_state != 0) ? 1 : 0);
            check("period_start", int'(period_start), int'(m_ps));
        end
    end

    int p0_exp [32] = '{1, 2, 3, 4, 5, 6, 7, 8,  8, 8, 8, 8, 8, 8, 8, 8,
                        7, 6, 5, 4, 3, 2, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0};

    task automatic wait_idle(input string name);
        int j;
        for (j = 0; j < 300; j++) begin
            @(negedge clk);
            if (!running) break;
        end
        check(name, (j < 300) ? 1 : 0, 1);
    endtask

    initial begin
        int j;
        int n;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_pos", int'(clkpos_code), 0);
        check("rst_neg", int'(clkneg_code), 16'h8888);
        check("rst_active", int'(active), 0);
        check("rst_running", int'(running), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_neg", int'(clkneg_code), 16'h8888);

        // Start-up with en held, then drain from cycle 40
        #1 en = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("start_p0_c%0d", i), field(clkpos_code, 0), (i < 32) ? p0_exp[i] : i - 31);
            if (i == 0)  check("ps_c0", int'(period_start), 1);
            if (i == 7)  check("p1_c7", field(clkpos_code, 1), 0);
            if (i == 8)  check("p1_c8", field(clkpos_code, 1), 1);
            if (i == 15) check("p2_c15", field(clkpos_code, 2), 0);
            if (i == 16) check("act_c16", int'(active), 4'b0111);
            if (i == 23) check("p3_c23", field(clkpos_code, 3), 0);
            if (i == 24) check("p3_c24", field(clkpos_code, 3), 1);
            if (i == 24) check("act_c24", int'(active), 4'b1110);
            if (i == 31) check("ps_c31", int'(period_start), 0);
            if (i == 32) check("ps_c32", int'(period_start), 1);
            if (i == 32) check("act_c32", int'(active), 4'b1101);
        end
        #1 en = 1'b0;
        for (j = 0; j < 200; j++) begin
            @(negedge clk);
            if (!running) break;
        end
        check("drain_len", j, 17);
        check("drain_pos", int'(clkpos_code), 0);
        check("drain_neg", int'(clkneg_code), 16'h8888);

        // Re-enable during drain
        repeat (2) @(negedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 72; i++) begin
            @(negedge clk);
            if (i == 41) check("reen_run_c41", int'(running), 1);
            if (i == 44) check("reen_act_c44", int'(active), 4'b1001);
            if (i == 56) check("reen_act_c56", int'(active), 4'b1100);
            if (i == 64) check("reen_act_c64", int'(active), 4'b1101);
            if (i == 64) check("reen_ps_c64", int'(period_start), 1);
            if (i == 39) #1 en = 1'b0;
            if (i == 43) #1 en = 1'b1;
        end
        #1 en = 1'b0;
        wait_idle("reen_idle");

        // Async reset mid-hold, then start-up repeats
        #1 en = 1'b1;
        @(posedge clk);
        repeat (13) @(negedge clk);
        check("pre_rst_p0", field(clkpos_code, 0), 8);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pos", int'(clkpos_code), 0);
        check("arst_neg", int'(clkneg_code), 16'h8888);
        check("arst_active", int'(active), 0);
        check("arst_running", int'(running), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_p0", field(clkpos_code, 0), 1);
        check("restart_ps", int'(period_start), 1);

        // Stall mid-evaluate of phase 2 at code 3
        n = 0;
        repeat (18) begin
            @(negedge clk);
            n++;
        end
        check("stall_pre_p2", field(clkpos_code, 2), 3);
        #1 stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            n++;
            check($sformatf("stall_hold_%0d", s), field(clkpos_code, 2), 3);
        end
        #1 stall = 1'b0;
        @(negedge clk);
        n++;
        check("stall_resume_p2", field(clkpos_code, 2), 4);
        for (j = 0; j < 100; j++) begin
            @(negedge clk);
            n++;
            if (period_start) break;
        end
        check("stall_period", n, 37);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 39) == 0) en = ~en;
            stall = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        #1 begin
            en    = 1'b0;
            stall = 1'b0;
        end
        wait_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
